// File: rtl/boundary_loader_pkg.sv
// Shared definitions for the boundary-cell configuration loader:
// FSM state encoding, default value width and index-width helper.
package boundary_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int W_DEFAULT = 8;

  // Bit width needed to index n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boundary_loader_step_tick_divider.sv
// Free-running step divider: counts 0..TICK_DIV-1 while enabled and
// raises a registered Tick on the cycle the count sits at TICK_DIV-1.
module step_tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic Tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tick;

  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);

  // Tick is registered from the next count so it lines up with count == LAST.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == LAST);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign Tick = r_tick;

endmodule

// File: rtl/boundary_loader.sv
// Boundary-cell configuration front end: assembles NCELLS values from a byte
// stream, commits them atomically with the mode, then paces the step tick.
module boundary_loader
  import boundary_loader_pkg::*;
#(
  parameter int NCELLS   = 4,
  parameter int W        = W_DEFAULT,
  parameter int TICK_DIV = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                START,
  input  logic                HALT,
  input  logic                MODE,
  input  logic [W-1:0]        CFG_DATA,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  output logic [NCELLS*W-1:0] INIT_VALS,
  output logic                VonNeumann,
  output logic                Tick,
  output logic                LOAD_DONE,
  output logic                Busy
);

  localparam int            IW       = idx_w(NCELLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCELLS - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [W-1:0]        r_shadow [NCELLS];
  logic                r_pend_mode;
  logic [NCELLS*W-1:0] r_init_vals;
  logic [NCELLS*W-1:0] w_commit_vals;
  logic                r_vn;
  logic                r_load_done;
  logic                w_hs;
  logic                w_last_hs;
  logic                w_load_entry;
  logic                w_div_en;
  logic                w_div_tick;

  assign CFG_READY    = (r_state == ST_LOAD) && !HALT;
  assign w_hs         = CFG_READY && CFG_VALID;
  assign w_last_hs    = w_hs && (r_idx == LAST_IDX);
  assign w_load_entry = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (START && !HALT) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (HALT)           w_state_nxt = ST_IDLE;
        else if (w_last_hs) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (HALT)       w_state_nxt = ST_IDLE;
        else if (START) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The final byte bypasses the shadow so the whole set commits on its handshake.
  always_comb begin
    w_commit_vals = '0;
    for (int i = 0; i < NCELLS; i++) begin
      w_commit_vals[i*W +: W] = (IW'(i) == r_idx) ? CFG_DATA : r_shadow[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_idx       <= '0;
      r_pend_mode <= 1'b0;
      r_init_vals <= '0;
      r_vn        <= 1'b0;
      r_load_done <= 1'b0;
      for (int i = 0; i < NCELLS; i++) r_shadow[i] <= '0;
    end else begin
      r_load_done <= w_last_hs;
      if (w_load_entry) begin
        r_idx       <= '0;
        r_pend_mode <= MODE;
      end else if (w_hs) begin
        r_shadow[r_idx] <= CFG_DATA;
        r_idx           <= r_idx + IW'(1);
      end
      if (w_last_hs) begin
        r_init_vals <= w_commit_vals;
        r_vn        <= r_pend_mode;
      end
    end
  end

  assign w_div_en = (r_state == ST_RUN) && !HALT && !START;

  step_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .Clk  (Clk),
    .Reset(Reset),
    .en   (w_div_en),
    .clr  (w_last_hs),
    .Tick (w_div_tick)
  );

  // HALT, or a reconfigure START, silences a tick already in flight.
  assign Tick       = w_div_tick && (r_state == ST_RUN) && !HALT && !START;
  assign INIT_VALS  = r_init_vals;
  assign VonNeumann = r_vn;
  assign LOAD_DONE  = r_load_done;
  assign Busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_boundary_loader.sv
// Self-checking bench for boundary_loader: scoreboard of expected commits
// plus per-scenario tasks for reset, loading, abort, reconfigure and halt.
module tb_boundary_loader;

  localparam int NCELLS   = 4;
  localparam int W        = 8;
  localparam int TICK_DIV = 4;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                START;
  logic                HALT;
  logic                MODE;
  logic [W-1:0]        CFG_DATA;
  logic                CFG_VALID;
  logic                CFG_READY;
  logic [NCELLS*W-1:0] INIT_VALS;
  logic                VonNeumann;
  logic                Tick;
  logic                LOAD_DONE;
  logic                Busy;

  typedef struct packed {
    logic [NCELLS*W-1:0] vals;
    logic                mode;
  } exp_t;

  exp_t                exp_q[$];
  logic [NCELLS*W-1:0] committed;
  logic                committed_mode;
  int                  errors = 0;
  int                  checks = 0;

  always #5 Clk = ~Clk;

  boundary_loader #(
    .NCELLS  (NCELLS),
    .W       (W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .START     (START),
    .HALT      (HALT),
    .MODE      (MODE),
    .CFG_DATA  (CFG_DATA),
    .CFG_VALID (CFG_VALID),
    .CFG_READY (CFG_READY),
    .INIT_VALS (INIT_VALS),
    .VonNeumann(VonNeumann),
    .Tick      (Tick),
    .LOAD_DONE (LOAD_DONE),
    .Busy      (Busy)
  );

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_load(input logic m);
    START = 1'b1;
    MODE  = m;
    cyc();
    START = 1'b0;
    MODE  = 1'b0;
  endtask

  // Back-to-back bytes; the expected commit is queued as the last byte is offered.
  task automatic drive_bytes(input logic [NCELLS*W-1:0] v, input logic m);
    exp_t e;
    for (int i = 0; i < NCELLS; i++) begin
      CFG_VALID = 1'b1;
      CFG_DATA  = v[i*W +: W];
      if (i == NCELLS - 1) begin
        e.vals = v;
        e.mode = m;
        exp_q.push_back(e);
      end
      cyc();
    end
    CFG_VALID = 1'b0;
    CFG_DATA  = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; START = 0; HALT = 0; MODE = 0; CFG_DATA = '0; CFG_VALID = 0;
    cyc();
    cyc();
    checks++;
    if ({INIT_VALS, VonNeumann, Tick, LOAD_DONE, Busy, CFG_READY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {INIT_VALS, VonNeumann, Tick, LOAD_DONE, Busy, CFG_READY});
    end
    Reset = 1'b0;
    cyc();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", Busy); end
    committed = '0;
    committed_mode = 1'b0;
  endtask

  task automatic test_normal_load();
    exp_t e;
    start_load(1'b1);
    checks++;
    if (CFG_READY !== 1'b1) begin errors++; $display("FAIL normal_ready: got %b want 1", CFG_READY); end
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL normal_busy: got %b want 1", Busy); end
    drive_bytes(32'h44332211, 1'b1);
    for (int k = 0; k < 20 && LOAD_DONE !== 1'b1; k++) cyc();
    checks++;
    if (LOAD_DONE !== 1'b1) begin errors++; $display("FAIL normal_load_done: got %b want 1", LOAD_DONE); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL normal_scoreboard: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      if (INIT_VALS !== e.vals || VonNeumann !== e.mode) begin
        errors++;
        $display("FAIL normal_commit: got %h/%b want %h/%b", INIT_VALS, VonNeumann, e.vals, e.mode);
      end
      committed = e.vals; committed_mode = e.mode;
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (Tick !== ((k % TICK_DIV) == TICK_DIV - 1)) begin
        errors++;
        $display("FAIL normal_tick k=%0d: got %b want %b", k, Tick, (k % TICK_DIV) == TICK_DIV - 1);
      end
      if (k == 1) begin
        checks++;
        if (LOAD_DONE !== 1'b0) begin errors++; $display("FAIL normal_done_pulse: got %b want 0", LOAD_DONE); end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_run();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({INIT_VALS, VonNeumann, Tick, LOAD_DONE, Busy, CFG_READY} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got %h want 0",
               {INIT_VALS, VonNeumann, Tick, LOAD_DONE, Busy, CFG_READY});
    end
    cyc();
    Reset = 1'b0;
    cyc();
    checks++;
    if (Busy !== 1'b0 || CFG_READY !== 1'b0) begin
      errors++; $display("FAIL midrun_idle: got busy=%b ready=%b want 0/0", Busy, CFG_READY);
    end
    committed = '0;
    committed_mode = 1'b0;
  endtask

  task automatic test_stalled_stream();
    exp_t                e;
    logic [NCELLS*W-1:0] v = 32'h44332211;
    int                  gap;
    start_load(1'b1);
    for (int i = 0; i < NCELLS; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        CFG_VALID = 1'b0;
        CFG_DATA  = 8'hFF;
        #1;
        checks++;
        if (INIT_VALS !== committed || LOAD_DONE !== 1'b0) begin
          errors++; $display("FAIL stall_hold: got %h/%b want %h/0", INIT_VALS, LOAD_DONE, committed);
        end
        cyc();
      end
      CFG_VALID = 1'b1;
      CFG_DATA  = v[i*W +: W];
      if (i == NCELLS - 1) begin
        e.vals = v; e.mode = 1'b1;
        exp_q.push_back(e);
      end
      #1;
      checks++;
      if (INIT_VALS !== committed) begin
        errors++; $display("FAIL stall_prehs: got %h want %h", INIT_VALS, committed);
      end
      cyc();
    end
    CFG_VALID = 1'b0;
    for (int k = 0; k < 20 && LOAD_DONE !== 1'b1; k++) cyc();
    checks++;
    if (LOAD_DONE !== 1'b1) begin errors++; $display("FAIL stall_load_done: got %b want 1", LOAD_DONE); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL stall_scoreboard: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      if (INIT_VALS !== e.vals || VonNeumann !== e.mode) begin
        errors++;
        $display("FAIL stall_commit: got %h/%b want %h/%b", INIT_VALS, VonNeumann, e.vals, e.mode);
      end
      committed = e.vals; committed_mode = e.mode;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    HALT = 1'b1;
    cyc();
    HALT = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_halt_run: got busy=%b want 0", Busy); end
    start_load(1'b0);
    drive_bytes(32'h01020304, 1'b0);
    for (int k = 0; k < 20 && LOAD_DONE !== 1'b1; k++) cyc();
    checks++;
    if (exp_q.size() == 0 || LOAD_DONE !== 1'b1) begin
      errors++; $display("FAIL abort_first_commit: got done=%b want 1", LOAD_DONE);
    end else begin
      e = exp_q.pop_front();
      if (INIT_VALS !== e.vals || VonNeumann !== e.mode) begin
        errors++;
        $display("FAIL abort_commit: got %h/%b want %h/%b", INIT_VALS, VonNeumann, e.vals, e.mode);
      end
      committed = e.vals; committed_mode = e.mode;
    end
    start_load(1'b1);
    for (int i = 0; i < 2; i++) begin
      CFG_VALID = 1'b1;
      CFG_DATA  = 8'hEE - 8'(i * 17);
      cyc();
    end
    HALT = 1'b1;
    CFG_DATA = 8'h77;
    #1;
    checks++;
    if (CFG_READY !== 1'b0) begin errors++; $display("FAIL abort_ready_gate: got %b want 0", CFG_READY); end
    cyc();
    HALT = 1'b0;
    CFG_VALID = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b want 0", Busy); end
    checks++;
    if (INIT_VALS !== committed || VonNeumann !== committed_mode || LOAD_DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_keep: got %h/%b/%b want %h/%b/0",
               INIT_VALS, VonNeumann, LOAD_DONE, committed, committed_mode);
    end
    start_load(1'b0);
    drive_bytes(32'h40302010, 1'b0);
    for (int k = 0; k < 20 && LOAD_DONE !== 1'b1; k++) cyc();
    checks++;
    if (exp_q.size() == 0 || LOAD_DONE !== 1'b1) begin
      errors++; $display("FAIL abort_reload: got done=%b want 1", LOAD_DONE);
    end else begin
      e = exp_q.pop_front();
      if (INIT_VALS !== e.vals || VonNeumann !== e.mode) begin
        errors++;
        $display("FAIL abort_reload_commit: got %h/%b want %h/%b", INIT_VALS, VonNeumann, e.vals, e.mode);
      end
      committed = e.vals; committed_mode = e.mode;
    end
  endtask

  task automatic test_reconfigure();
    exp_t e;
    cyc();
    START = 1'b1;
    MODE  = 1'b1;
    #1;
    checks++;
    if (Tick !== 1'b0) begin errors++; $display("FAIL reconf_start_tick: got %b want 0", Tick); end
    cyc();
    START = 1'b0;
    MODE  = 1'b0;
    checks++;
    if (CFG_READY !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL reconf_ready: got ready=%b busy=%b want 1/1", CFG_READY, Busy);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (Tick !== 1'b0 || INIT_VALS !== committed) begin
        errors++; $display("FAIL reconf_quiet k=%0d: got %b/%h want 0/%h", k, Tick, INIT_VALS, committed);
      end
      cyc();
    end
    drive_bytes(32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 20 && LOAD_DONE !== 1'b1; k++) cyc();
    checks++;
    if (exp_q.size() == 0 || LOAD_DONE !== 1'b1) begin
      errors++; $display("FAIL reconf_done: got done=%b want 1", LOAD_DONE);
    end else begin
      e = exp_q.pop_front();
      if (INIT_VALS !== e.vals || VonNeumann !== e.mode) begin
        errors++;
        $display("FAIL reconf_commit: got %h/%b want %h/%b", INIT_VALS, VonNeumann, e.vals, e.mode);
      end
      committed = e.vals; committed_mode = e.mode;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Tick !== ((k % TICK_DIV) == TICK_DIV - 1)) begin
        errors++;
        $display("FAIL reconf_tick k=%0d: got %b want %b", k, Tick, (k % TICK_DIV) == TICK_DIV - 1);
      end
      cyc();
    end
  endtask

  task automatic test_halt_start_run();
    exp_t e;
    start_load(1'b0);
    drive_bytes(32'hCAFE0123, 1'b0);
    for (int k = 0; k < 20 && LOAD_DONE !== 1'b1; k++) cyc();
    checks++;
    if (exp_q.size() == 0 || LOAD_DONE !== 1'b1) begin
      errors++; $display("FAIL hs_done: got done=%b want 1", LOAD_DONE);
    end else begin
      e = exp_q.pop_front();
      if (INIT_VALS !== e.vals || VonNeumann !== e.mode) begin
        errors++;
        $display("FAIL hs_commit: got %h/%b want %h/%b", INIT_VALS, VonNeumann, e.vals, e.mode);
      end
    end
    for (int k = 0; k < TICK_DIV - 1; k++) cyc();
    HALT  = 1'b1;
    START = 1'b1;
    #1;
    checks++;
    if (Tick !== 1'b0) begin errors++; $display("FAIL hs_tick_gate: got %b want 0", Tick); end
    cyc();
    HALT  = 1'b0;
    START = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || CFG_READY !== 1'b0 || Tick !== 1'b0) begin
      errors++;
      $display("FAIL hs_idle: got busy=%b ready=%b tick=%b want 0/0/0", Busy, CFG_READY, Tick);
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_reset_mid_run();
    test_stalled_stream();
    test_abort();
    test_reconfigure();
    test_halt_start_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
